// File: rtl/sram_col_mux_ctrl.sv
// sram_col_mux_ctrl: column multiplexer and precharge/sense/write sequencer for SRAM macros.
// One request at a time: IDLE -> PRECH -> (SENSE | WRITE) -> RESP -> IDLE.
// Optional feature: define SRAM_COLMUX_WMASK_EN to add a per-byte write mask port (req_wmask).
module sram_col_mux_ctrl #(
    parameter int DATA_W        = 32,
    parameter int COL_MUX       = 4,
    parameter int SEL_W         = $clog2(COL_MUX),
    parameter int PRECHARGE_CYC = 1,
    parameter int SENSE_CYC     = 2,
    parameter int WRITE_CYC     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [SEL_W-1:0]          req_col,
    input  logic [DATA_W-1:0]         req_wdata,
`ifdef SRAM_COLMUX_WMASK_EN
    input  logic [DATA_W/8-1:0]       req_wmask,
`endif
    output logic [COL_MUX-1:0]        col_sel,
    output logic                      precharge,
    output logic                      sense_en,
    output logic [DATA_W*COL_MUX-1:0] bl_wen,
    output logic [DATA_W*COL_MUX-1:0] bl_wdata,
    input  logic [DATA_W*COL_MUX-1:0] bl_rdata,
    output logic                      rsp_valid,
    output logic                      rsp_err,
    output logic [DATA_W-1:0]         rsp_rdata
);

    localparam int MAX_PS  = (PRECHARGE_CYC > SENSE_CYC) ? PRECHARGE_CYC : SENSE_CYC;
    localparam int MAX_CYC = (MAX_PS > WRITE_CYC) ? MAX_PS : WRITE_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Counters are loaded with (cycles - 1) and the state exits when they reach zero.
    localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRECHARGE_CYC - 1);
    localparam logic [CNT_W-1:0] SNS_LOAD = CNT_W'(SENSE_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WRITE_CYC - 1);
    localparam logic [SEL_W:0]   COL_LIM  = (SEL_W + 1)'(COL_MUX);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRECH = 3'd1,
        S_SENSE = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                write_q, write_d;
    logic [SEL_W-1:0]    col_q, col_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   bit_en;
    logic [DATA_W-1:0]   rdata_sel;
    logic [COL_MUX-1:0]  col_onehot;

    assign col_onehot = {{(COL_MUX-1){1'b0}}, 1'b1} << col_q;
    assign rsp_rdata  = rdata_q;

`ifdef SRAM_COLMUX_WMASK_EN
    logic [DATA_W/8-1:0] wmask_q, wmask_d;

    // Expand the latched byte mask to one enable per data bit
    always_comb begin
        bit_en = '0;
        for (int b = 0; b < DATA_W; b++) begin
            bit_en[b] = wmask_q[b/8];
        end
    end
`else
    assign bit_en = {DATA_W{1'b1}};
`endif

    // Pick the selected column's sensed value for every data bit
    always_comb begin
        rdata_sel = '0;
        for (int b = 0; b < DATA_W; b++) begin
            for (int c = 0; c < COL_MUX; c++) begin
                if (col_q == SEL_W'(c)) begin
                    rdata_sel[b] = bl_rdata[b*COL_MUX + c];
                end
            end
        end
    end

    // Next state, phase counter, request latching and read-data capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        write_d = write_q;
        col_d   = col_q;
        wdata_d = wdata_q;
        err_d   = err_q;
`ifdef SRAM_COLMUX_WMASK_EN
        wmask_d = wmask_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_PRECH;
                    cnt_d   = PRE_LOAD;
                    write_d = req_write;
                    col_d   = req_col;
                    wdata_d = req_wdata;
                    err_d   = ({1'b0, req_col} >= COL_LIM);
`ifdef SRAM_COLMUX_WMASK_EN
                    wmask_d = req_wmask;
`endif
                end
            end
            S_PRECH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (err_q) begin
                    // Out-of-range column: skip the array access entirely.
                    state_d = S_RESP;
                end else if (write_q) begin
                    state_d = S_WRITE;
                    cnt_d   = WR_LOAD;
                end else begin
                    state_d = S_SENSE;
                    cnt_d   = SNS_LOAD;
                end
            end
            S_SENSE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_RESP;
                    rdata_d = rdata_sel;
                end
            end
            S_WRITE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        req_ready = 1'b0;
        precharge = 1'b0;
        sense_en  = 1'b0;
        col_sel   = '0;
        bl_wen    = '0;
        bl_wdata  = '0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        case (state_q)
            S_IDLE:  req_ready = 1'b1;
            S_PRECH: precharge = 1'b1;
            S_SENSE: begin
                sense_en = 1'b1;
                col_sel  = col_onehot;
            end
            S_WRITE: begin
                col_sel = col_onehot;
                for (int b = 0; b < DATA_W; b++) begin
                    for (int c = 0; c < COL_MUX; c++) begin
                        bl_wdata[b*COL_MUX + c] = wdata_q[b];
                        bl_wen[b*COL_MUX + c]   = bit_en[b] && (col_q == SEL_W'(c));
                    end
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
            end
            default: ;
        endcase
    end

    // Control state and returned read data, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Request fields; only observed in states entered after an accept, so no reset needed
    always_ff @(posedge clk) begin
        write_q <= write_d;
        col_q   <= col_d;
        wdata_q <= wdata_d;
        err_q   <= err_d;
`ifdef SRAM_COLMUX_WMASK_EN
        wmask_q <= wmask_d;
`endif
    end

endmodule

// File: tb/tb_sram_col_mux_ctrl.sv
// Testbench for sram_col_mux_ctrl: transaction-level model compared every cycle, directed
// scenarios with literal expectations, randomized traffic, and a COL_MUX=3 instance for
// out-of-range columns. Build with SRAM_COLMUX_WMASK_EN to also exercise the byte mask.
module tb_sram_col_mux_ctrl;

    localparam int DW = 32;
    localparam int CM = 4;
    localparam int P  = 1;
    localparam int S  = 2;
    localparam int W  = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_write = 1'b0;
    logic [1:0]      req_col = '0;
    logic [DW-1:0]   req_wdata = '0;
    logic [3:0]      req_wmask = 4'hF;
    logic [CM-1:0]   col_sel;
    logic            precharge;
    logic            sense_en;
    logic [127:0]    bl_wen;
    logic [127:0]    bl_wdata;
    logic [127:0]    bl_rdata = '0;
    logic            rsp_valid;
    logic            rsp_err;
    logic [DW-1:0]   rsp_rdata;

    // second instance: 8 bits, 3 columns, so column index 3 is out of range
    logic            r3_valid = 1'b0;
    logic            r3_ready;
    logic            r3_write = 1'b0;
    logic [1:0]      r3_col = '0;
    logic [7:0]      r3_wdata = '0;
    logic [0:0]      r3_wmask = 1'b1;
    logic [2:0]      col_sel3;
    logic            prech3;
    logic            sense3;
    logic [23:0]     wen3;
    logic [23:0]     wdat3;
    logic [23:0]     rdat3 = '0;
    logic            rv3;
    logic            re3;
    logic [7:0]      rd3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_col_mux_ctrl u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_col(req_col), .req_wdata(req_wdata),
`ifdef SRAM_COLMUX_WMASK_EN
        .req_wmask(req_wmask),
`endif
        .col_sel(col_sel), .precharge(precharge), .sense_en(sense_en),
        .bl_wen(bl_wen), .bl_wdata(bl_wdata), .bl_rdata(bl_rdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata)
    );

    sram_col_mux_ctrl #(.DATA_W(8), .COL_MUX(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(r3_valid), .req_ready(r3_ready), .req_write(r3_write),
        .req_col(r3_col), .req_wdata(r3_wdata),
`ifdef SRAM_COLMUX_WMASK_EN
        .req_wmask(r3_wmask),
`endif
        .col_sel(col_sel3), .precharge(prech3), .sense_en(sense3),
        .bl_wen(wen3), .bl_wdata(wdat3), .bl_rdata(rdat3),
        .rsp_valid(rv3), .rsp_err(re3), .rsp_rdata(rd3)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // ---------------- reference model helpers ----------------
    function automatic logic [127:0] pat(input logic [31:0] v, input int col);
        logic [127:0] r;
        for (int b = 0; b < DW; b++)
            for (int c = 0; c < CM; c++)
                r[b*CM + c] = (c == col) ? v[b] : ~v[b];
        return r;
    endfunction

    function automatic logic [23:0] pat3(input logic [7:0] v, input int col);
        logic [23:0] r;
        for (int b = 0; b < 8; b++)
            for (int c = 0; c < 3; c++)
                r[b*3 + c] = (c == col) ? v[b] : ~v[b];
        return r;
    endfunction

    function automatic logic [127:0] exp_wen(input int col, input logic [3:0] mk);
        logic [127:0] r;
        r = '0;
        for (int b = 0; b < DW; b++) r[b*CM + col] = mk[b/8];
        return r;
    endfunction

    function automatic logic [127:0] exp_wdat(input logic [31:0] wd);
        logic [127:0] r;
        for (int b = 0; b < DW; b++)
            for (int c = 0; c < CM; c++) r[b*CM + c] = wd[b];
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [127:0] bl, input int col);
        logic [31:0] r;
        for (int b = 0; b < DW; b++) r[b] = bl[b*CM + col];
        return r;
    endfunction

    // Model: an accepted op is at offset d (1 = first cycle after accept). Cycles 1..P
    // precharge, the next L cycles access the column, then one response cycle.
    bit          m_busy = 0;
    int          m_d = 0;
    bit          m_wr = 0;
    int          m_col = 0;
    logic [31:0] m_wd = '0;
    logic [3:0]  m_mk = 4'hF;
    bit          m_err = 0;
    logic [31:0] m_rd = '0;
    bit          armed = 0;

    task automatic compare_loop();
        int L;
        bit pre, act, rsp;
        forever begin
            @(negedge clk);
            L   = m_err ? 0 : (m_wr ? W : S);
            pre = m_busy && (m_d <= P);
            act = m_busy && (m_d > P) && (m_d <= P + L);
            rsp = m_busy && (m_d == P + L + 1);
            if (armed) begin
                chk("req_ready", 128'(req_ready), 128'(!m_busy));
                chk("precharge", 128'(precharge), 128'(pre));
                chk("sense_en", 128'(sense_en), 128'(act && !m_wr));
                chk("col_sel", 128'(col_sel), act ? 128'(4'b0001 << m_col) : 128'(0));
                chk("bl_wen", bl_wen, (act && m_wr) ? exp_wen(m_col, m_mk) : 128'(0));
                if (act && m_wr) chk("bl_wdata", bl_wdata, exp_wdat(m_wd));
                chk("rsp_valid", 128'(rsp_valid), 128'(rsp));
                chk("rsp_err", 128'(rsp_err), 128'(rsp && m_err));
                chk("rsp_rdata", 128'(rsp_rdata), 128'(m_rd));
                chk("exclusive", 128'((32'(precharge) + 32'(sense_en) + 32'(|bl_wen)) <= 1), 128'(1));
                chk("onehot", 128'($countones(col_sel) <= 1), 128'(1));
            end
            // advance to what the next rising edge produces
            if (!rst_n) begin
                m_busy = 0;
                m_rd   = '0;
                armed  = 1;
            end else if (m_busy) begin
                if (!m_err && !m_wr && m_d == P + S) m_rd = extract(bl_rdata, m_col);
                if (m_d == P + L + 1) m_busy = 0;
                else m_d++;
            end else if (req_valid) begin
                m_busy = 1;
                m_d    = 1;
                m_wr   = req_write;
                m_col  = int'(req_col);
                m_wd   = req_wdata;
                m_err  = (m_col >= CM);
`ifdef SRAM_COLMUX_WMASK_EN
                m_mk   = req_wmask;
`else
                m_mk   = 4'hF;
`endif
            end
        end
    endtask

    // ---------------- directed helpers ----------------
    task automatic run_op(input logic wr, input logic [1:0] col, input logic [31:0] wd,
                          input logic [3:0] mk, output int lat, output int n_pre,
                          output int n_sns, output int n_wen, output logic [127:0] wen_s,
                          output logic [127:0] wdat_s, output logic [3:0] cs_s,
                          output logic err_s, output logic [31:0] rd_s);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_col = col; req_wdata = wd; req_wmask = mk;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; n_pre = 0; n_sns = 0; n_wen = 0;
        wen_s = '0; wdat_s = '0; cs_s = '0; err_s = 1'b0; rd_s = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (precharge) n_pre++;
            if (sense_en) begin n_sns++; cs_s = col_sel; end
            if (|bl_wen) begin n_wen++; wen_s = bl_wen; wdat_s = bl_wdata; cs_s = col_sel; end
            if (rsp_valid) begin lat = i; err_s = rsp_err; rd_s = rsp_rdata; break; end
        end
    endtask

    task automatic run3(input logic wr, input logic [1:0] col, input logic [7:0] wd,
                        output int lat, output int act, output logic err, output logic [7:0] rd);
        @(posedge clk); #1;
        r3_valid = 1'b1; r3_write = wr; r3_col = col; r3_wdata = wd;
        @(posedge clk); #1;
        r3_valid = 1'b0;
        lat = 0; act = 0; err = 1'b0; rd = '0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if ((|col_sel3) || sense3 || (|wen3)) act++;
            if (rv3) begin lat = i; err = re3; rd = rd3; break; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int lat, n_pre, n_sns, n_wen, cnt, act3;
        logic [127:0] wen_s, wdat_s;
        logic [3:0]   cs_s;
        logic         err_s;
        logic [31:0]  rd_s;
        logic [7:0]   rd8;
        longint       t_acc[3];
        logic         op_wr[3];
        logic [1:0]   op_col[3];

        fork
            compare_loop();
        join_none

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Write col 2
        run_op(1'b1, 2'd2, 32'hA5A5_0F0F, 4'hF, lat, n_pre, n_sns, n_wen, wen_s, wdat_s, cs_s, err_s, rd_s);
        chk("wr_latency", 128'(lat), 128'(3));
        chk("wr_prech_cycles", 128'(n_pre), 128'(1));
        chk("wr_wen_cycles", 128'(n_wen), 128'(1));
        chk("wr_bl_wen", wen_s, 128'h44444444444444444444444444444444);
        chk("wr_bl_wdata", wdat_s, 128'hF0F00F0FF0F00F0F0000FFFF0000FFFF);
        chk("wr_col_sel", 128'(cs_s), 128'(4'b0100));
        chk("wr_err", 128'(err_s), 128'(0));

        // Read col 3 with complementary data on the other columns
        bl_rdata = pat(32'hDEAD_BEEF, 3);
        run_op(1'b0, 2'd3, 32'h0, 4'hF, lat, n_pre, n_sns, n_wen, wen_s, wdat_s, cs_s, err_s, rd_s);
        chk("rd_latency", 128'(lat), 128'(4));
        chk("rd_sense_cycles", 128'(n_sns), 128'(2));
        chk("rd_col_sel", 128'(cs_s), 128'(4'b1000));
        chk("rd_data", 128'(rd_s), 128'(32'hDEAD_BEEF));
        chk("rd_no_wen", 128'(n_wen), 128'(0));

        // Reset for two edges in the middle of SENSE
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_col = 2'd1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 128'(req_ready), 128'(1));
        chk("rst_sense", 128'(sense_en), 128'(0));
        chk("rst_col_sel", 128'(col_sel), 128'(0));
        chk("rst_rdata", 128'(rsp_rdata), 128'(0));
        chk("rst_wdata", bl_wdata, 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin @(negedge clk); if (rsp_valid) cnt++; end
        chk("rst_no_rsp", 128'(cnt), 128'(0));

        // Back-to-back with req_valid held high
        bl_rdata = pat(32'hDEAD_BEEF, 3);
        op_wr[0] = 1'b0; op_col[0] = 2'd3;
        op_wr[1] = 1'b1; op_col[1] = 2'd1;
        op_wr[2] = 1'b0; op_col[2] = 2'd0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_write = op_wr[k]; req_col = op_col[k]; req_wdata = 32'h1234_5678;
            cnt = 0;
            do begin @(negedge clk); cnt++; end while (!req_ready && cnt < 20);
            chk("b2b_ready", 128'(req_ready), 128'(1));
            @(posedge clk);
            t_acc[k] = $time;
            #1;
        end
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("b2b_gap_read", 128'(t_acc[1] - t_acc[0]), 128'(50));
        chk("b2b_gap_write", 128'(t_acc[2] - t_acc[1]), 128'(40));
        chk("b2b_last_rdata", 128'(rsp_rdata), 128'(32'h2152_4110));

        // Three-column instance: legal read, out-of-range read/write, legal write
        rdat3 = pat3(8'h5A, 1);
        run3(1'b0, 2'd1, 8'h00, lat, act3, err_s, rd8);
        chk("c3_rd_latency", 128'(lat), 128'(4));
        chk("c3_rd_err", 128'(err_s), 128'(0));
        chk("c3_rd_data", 128'(rd8), 128'(8'h5A));
        rdat3 = pat3(8'hFF, 0);
        run3(1'b0, 2'd3, 8'h00, lat, act3, err_s, rd8);
        chk("c3_oor_rd_latency", 128'(lat), 128'(2));
        chk("c3_oor_rd_activity", 128'(act3), 128'(0));
        chk("c3_oor_rd_err", 128'(err_s), 128'(1));
        chk("c3_oor_rd_data", 128'(rd8), 128'(8'h5A));
        run3(1'b1, 2'd3, 8'hC3, lat, act3, err_s, rd8);
        chk("c3_oor_wr_latency", 128'(lat), 128'(2));
        chk("c3_oor_wr_activity", 128'(act3), 128'(0));
        chk("c3_oor_wr_err", 128'(err_s), 128'(1));
        run3(1'b1, 2'd2, 8'hC3, lat, act3, err_s, rd8);
        chk("c3_wr_latency", 128'(lat), 128'(3));
        chk("c3_wr_activity", 128'(act3), 128'(1));
        chk("c3_wr_err", 128'(err_s), 128'(0));
        chk("c3_wr_keeps_rdata", 128'(rd8), 128'(8'h5A));

`ifdef SRAM_COLMUX_WMASK_EN
        // Byte mask 0101 on column 0
        run_op(1'b1, 2'd0, 32'hFFFF_FFFF, 4'b0101, lat, n_pre, n_sns, n_wen, wen_s, wdat_s, cs_s, err_s, rd_s);
        chk("wm_latency", 128'(lat), 128'(3));
        chk("wm_bl_wen", wen_s, 128'h00000000111111110000000011111111);
        run_op(1'b1, 2'd1, 32'h0F0F_0F0F, 4'b0000, lat, n_pre, n_sns, n_wen, wen_s, wdat_s, cs_s, err_s, rd_s);
        chk("wm_zero_latency", 128'(lat), 128'(3));
        chk("wm_zero_wen", 128'(n_wen), 128'(0));
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            req_valid = ($urandom_range(0, 2) != 0);
            req_write = 1'($urandom_range(0, 1));
            req_col   = 2'($urandom_range(0, 3));
            req_wdata = $urandom;
            req_wmask = 4'($urandom_range(0, 15));
            bl_rdata  = {$urandom, $urandom, $urandom, $urandom};
            rst_n     = ($urandom_range(0, 99) != 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
